// File: rtl/pad_attr_update_arb.sv
// pad_attr_update_arb: round-robin arbiter applying one masked pad-attribute write at a time (req_i/pad_idx_i/attr_i/attr_warl_mask_i in; gnt_o, attr_o, attr_upd_o, busy_o, err_o out)
module pad_attr_update_arb #(
  parameter int NumReq = 2,
  parameter int NumPads = 8,
  parameter int AttrDw = 13,
  parameter int SettleCycles = 4,
  parameter int PadIdxW = $clog2(NumPads)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*PadIdxW-1:0]   pad_idx_i,
  input  logic [NumReq*AttrDw-1:0]    attr_i,
  input  logic [AttrDw-1:0]           attr_warl_mask_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumPads*AttrDw-1:0]   attr_o,
  output logic [NumPads-1:0]          attr_upd_o,
  output logic                        busy_o,
  output logic                        err_o
);
  localparam int RrW = NumReq > 1 ? $clog2(NumReq) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_e;
  state_e state, state_nxt;
  logic [RrW-1:0] rr_ptr, off, winner;
  logic [RrW:0] win_sum;
  logic found;
  logic [2*NumReq-1:0] req_rot;
  logic [7:0] cnt;
  logic [PadIdxW-1:0] cap_idx;
  logic [AttrDw-1:0] cap_attr;
  logic cap_ok;
  logic [NumPads-1:0][AttrDw-1:0] attr_q;

  assign req_rot = {req_i, req_i} >> rr_ptr;
  always_comb begin
    off = '0;
    found = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--)
      if (req_rot[k]) begin
        off = RrW'(k);
        found = 1'b1;
      end
  end
  assign win_sum = {1'b0, rr_ptr} + {1'b0, off};
  assign winner = win_sum >= (RrW+1)'(NumReq) ? RrW'(win_sum - (RrW+1)'(NumReq)) : win_sum[RrW-1:0];
  assign cap_ok = {1'b0, cap_idx} < (PadIdxW+1)'(NumPads);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state == IDLE   ? (found ? APPLY : IDLE) :
                state == APPLY  ? (SettleCycles == 0 ? IDLE : SETTLE) :
                                  (cnt == 8'd1 ? IDLE : SETTLE);
  end

  always_comb begin
    busy_o = state != IDLE;
    gnt_o = (state == IDLE && found && !rst_i) ? NumReq'(1) << winner : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      cap_idx <= '0;
      cap_attr <= '0;
    end else if (|gnt_o) begin
      rr_ptr <= winner == RrW'(NumReq - 1) ? '0 : winner + 1'b1;
      cap_idx <= pad_idx_i[winner*PadIdxW +: PadIdxW];
      cap_attr <= attr_i[winner*AttrDw +: AttrDw] & attr_warl_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else if (state == APPLY) cnt <= 8'(SettleCycles);
    else if (state == SETTLE) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      attr_q <= '0;
      attr_upd_o <= '0;
      err_o <= 1'b0;
    end else begin
      attr_upd_o <= '0;
      err_o <= state == APPLY && !cap_ok;
      if (state == APPLY && cap_ok) begin
        attr_q[cap_idx] <= cap_attr;
        attr_upd_o[cap_idx] <= 1'b1;
      end
    end
  end

  assign attr_o = attr_q;
endmodule
